// File: rtl/hazard_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared types for the pipeline hazard scoreboard: forward-select encodings,
// the in-flight tracker entry and the EX-stage source-operand record.
// Register numbers are stored at HZ_RW bits so the types do not depend on
// the AW parameter of the instantiating module (AW must be <= HZ_RW).
// ----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int HZ_RW = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [HZ_RW-1:0] rd;
        logic             reg_wr;
        logic             mem_to_reg;
    } trk_entry_t;

    typedef struct packed {
        logic [HZ_RW-1:0] rs;
        logic [HZ_RW-1:0] rt;
        logic             rs_used;
        logic             rt_used;
    } ex_src_t;

    // True when the entry will write register r; register 0 never counts.
    function automatic logic writes_reg(input trk_entry_t e, input logic [HZ_RW-1:0] r);
        return e.valid & e.reg_wr & (e.rd != '0) & (e.rd == r);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_counter.sv
// ----------------------------------------------------------------------------
// hz_md_counter
// Mult/div occupancy timer. Loads a latency value when a mult/div enters EX,
// then counts down to zero; busy while non-zero.
// Ports:
//   i_clk       clock
//   i_rst_n     synchronous active-low reset
//   i_load      load i_load_val this edge
//   i_load_val  occupancy in cycles
//   o_busy      counter != 0
// ----------------------------------------------------------------------------
module hz_md_counter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_busy
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_busy = (r_cnt != 8'd0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Pipeline hazard detection for an ISS/EX/MEM/WB pipeline. Tracks the three
// in-flight instructions, raises stall/flush for load-use (forwarding mode),
// RAW (stall-only mode) and mult/div occupancy hazards, lets a taken branch
// override everything with a flush, and produces EX operand forward selects.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   iss_*_i                     decoded fields of the instruction in ISS
//   ex_branch_taken_i           branch/jump in EX resolved taken
//   stall_fetch_hz_o/iss_hz_o   hold PC / hold ISS register
//   flush_iss_hz_o/ex_hz_o      kill ISS instruction / bubble into EX
//   fwd_p1/p2_ex_mem_hz_o       EX operand select (00 RF, 01 MEM, 10 WB)
//   md_busy_hz_o                mult/div unit occupied
//   stall_cnt_hz_o              saturating stall-cycle counter
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int MD_LAT = 32,
    parameter int FWD_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_rs_i,
    input  logic [AW-1:0] iss_rt_i,
    input  logic          iss_rs_used_i,
    input  logic          iss_rt_used_i,
    input  logic [AW-1:0] iss_rd_i,
    input  logic          iss_reg_wr_i,
    input  logic          iss_mem_to_reg_i,
    input  logic          iss_md_i,
    input  logic          iss_md_rd_i,
    input  logic          ex_branch_taken_i,
    output logic          stall_fetch_hz_o,
    output logic          stall_iss_hz_o,
    output logic          flush_iss_hz_o,
    output logic          flush_ex_hz_o,
    output logic [1:0]    fwd_p1_ex_mem_hz_o,
    output logic [1:0]    fwd_p2_ex_mem_hz_o,
    output logic          md_busy_hz_o,
    output logic [15:0]   stall_cnt_hz_o
);

    localparam logic [7:0] L_MD_LAT = 8'(MD_LAT);
    localparam logic       L_FWD    = (FWD_EN != 0);

    trk_entry_t r_ex, r_mem, r_wb;
    ex_src_t    r_src;
    logic [15:0] r_stall_cnt;

    logic [HZ_RW-1:0] w_iss_rs, w_iss_rt, w_iss_rd;
    logic       w_rs_hit_ex, w_rt_hit_ex, w_rs_hit_mem, w_rt_hit_mem;
    logic       w_load_use, w_raw, w_md_hz, w_stall_req;
    logic       w_accept, w_md_busy;
    trk_entry_t w_ex_next;
    ex_src_t    w_src_next;

    assign w_iss_rs = HZ_RW'(iss_rs_i);
    assign w_iss_rt = HZ_RW'(iss_rt_i);
    assign w_iss_rd = HZ_RW'(iss_rd_i);

    assign w_rs_hit_ex  = iss_rs_used_i & writes_reg(r_ex,  w_iss_rs);
    assign w_rt_hit_ex  = iss_rt_used_i & writes_reg(r_ex,  w_iss_rt);
    assign w_rs_hit_mem = iss_rs_used_i & writes_reg(r_mem, w_iss_rs);
    assign w_rt_hit_mem = iss_rt_used_i & writes_reg(r_mem, w_iss_rt);

    // With forwarding only a load in EX is too late to bypass; without it
    // any writer still in EX or MEM must drain (WB writes before RF read).
    assign w_load_use = L_FWD & iss_valid_i & r_ex.mem_to_reg & (w_rs_hit_ex | w_rt_hit_ex);
    assign w_raw      = ~L_FWD & iss_valid_i &
                        (w_rs_hit_ex | w_rt_hit_ex | w_rs_hit_mem | w_rt_hit_mem);
    assign w_md_hz    = iss_valid_i & (iss_md_i | iss_md_rd_i) & w_md_busy;
    assign w_stall_req = w_load_use | w_raw | w_md_hz;

    always_comb begin
        stall_fetch_hz_o = 1'b0;
        stall_iss_hz_o   = 1'b0;
        flush_iss_hz_o   = 1'b0;
        flush_ex_hz_o    = 1'b0;
        if (ex_branch_taken_i) begin
            flush_iss_hz_o = 1'b1;
            flush_ex_hz_o  = 1'b1;
        end else if (w_stall_req) begin
            stall_fetch_hz_o = 1'b1;
            stall_iss_hz_o   = 1'b1;
            flush_ex_hz_o    = 1'b1;
        end
    end

    assign w_accept = iss_valid_i & ~stall_iss_hz_o & ~flush_iss_hz_o;

    always_comb begin
        w_ex_next  = '0;
        w_src_next = '0;
        if (w_accept) begin
            w_ex_next.valid      = 1'b1;
            w_ex_next.rd         = w_iss_rd;
            w_ex_next.reg_wr     = iss_reg_wr_i;
            w_ex_next.mem_to_reg = iss_mem_to_reg_i;
            w_src_next.rs        = w_iss_rs;
            w_src_next.rt        = w_iss_rt;
            w_src_next.rs_used   = iss_rs_used_i;
            w_src_next.rt_used   = iss_rt_used_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_src       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_ex  <= w_ex_next;
            r_src <= w_src_next;
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (stall_iss_hz_o && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt_hz_o = r_stall_cnt;

    hz_md_counter u_md_counter (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_accept & iss_md_i),
        .i_load_val (L_MD_LAT),
        .o_busy     (w_md_busy)
    );

    assign md_busy_hz_o = w_md_busy;

    // A load in MEM has no data yet; the load-use stall pushes its consumer
    // back one cycle so it is picked up from WB instead.
    logic w_p1_mem, w_p1_wb, w_p2_mem, w_p2_wb;

    assign w_p1_mem = r_src.rs_used & ~r_mem.mem_to_reg & writes_reg(r_mem, r_src.rs);
    assign w_p1_wb  = r_src.rs_used & writes_reg(r_wb, r_src.rs);
    assign w_p2_mem = r_src.rt_used & ~r_mem.mem_to_reg & writes_reg(r_mem, r_src.rt);
    assign w_p2_wb  = r_src.rt_used & writes_reg(r_wb, r_src.rt);

    always_comb begin
        fwd_p1_ex_mem_hz_o = FWD_RF;
        fwd_p2_ex_mem_hz_o = FWD_RF;
        if (L_FWD && r_ex.valid) begin
            if (w_p1_mem)     fwd_p1_ex_mem_hz_o = FWD_MEM;
            else if (w_p1_wb) fwd_p1_ex_mem_hz_o = FWD_WB;
            if (w_p2_mem)     fwd_p2_ex_mem_hz_o = FWD_MEM;
            else if (w_p2_wb) fwd_p2_ex_mem_hz_o = FWD_WB;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iss_valid_i;
    logic [4:0] iss_rs_i, iss_rt_i, iss_rd_i;
    logic       iss_rs_used_i, iss_rt_used_i, iss_reg_wr_i, iss_mem_to_reg_i;
    logic       iss_md_i, iss_md_rd_i, ex_branch_taken_i;

    logic        a_sf, a_si, a_fi, a_fe, a_busy;
    logic [1:0]  a_f1, a_f2;
    logic [15:0] a_cnt;
    logic        b_sf, b_si, b_fi, b_fe, b_busy;
    logic [1:0]  b_f1, b_f2;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.AW(5), .MD_LAT(4), .FWD_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .iss_valid_i(iss_valid_i),
        .iss_rs_i(iss_rs_i), .iss_rt_i(iss_rt_i),
        .iss_rs_used_i(iss_rs_used_i), .iss_rt_used_i(iss_rt_used_i),
        .iss_rd_i(iss_rd_i), .iss_reg_wr_i(iss_reg_wr_i),
        .iss_mem_to_reg_i(iss_mem_to_reg_i), .iss_md_i(iss_md_i),
        .iss_md_rd_i(iss_md_rd_i), .ex_branch_taken_i(ex_branch_taken_i),
        .stall_fetch_hz_o(a_sf), .stall_iss_hz_o(a_si),
        .flush_iss_hz_o(a_fi), .flush_ex_hz_o(a_fe),
        .fwd_p1_ex_mem_hz_o(a_f1), .fwd_p2_ex_mem_hz_o(a_f2),
        .md_busy_hz_o(a_busy), .stall_cnt_hz_o(a_cnt)
    );

    hazard_scoreboard #(.AW(5), .MD_LAT(4), .FWD_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .iss_valid_i(iss_valid_i),
        .iss_rs_i(iss_rs_i), .iss_rt_i(iss_rt_i),
        .iss_rs_used_i(iss_rs_used_i), .iss_rt_used_i(iss_rt_used_i),
        .iss_rd_i(iss_rd_i), .iss_reg_wr_i(iss_reg_wr_i),
        .iss_mem_to_reg_i(iss_mem_to_reg_i), .iss_md_i(iss_md_i),
        .iss_md_rd_i(iss_md_rd_i), .ex_branch_taken_i(ex_branch_taken_i),
        .stall_fetch_hz_o(b_sf), .stall_iss_hz_o(b_si),
        .flush_iss_hz_o(b_fi), .flush_ex_hz_o(b_fe),
        .fwd_p1_ex_mem_hz_o(b_f1), .fwd_p2_ex_mem_hz_o(b_f2),
        .md_busy_hz_o(b_busy), .stall_cnt_hz_o(b_cnt)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs, rt;
        logic       rsu, rtu;
        logic [4:0] rd;
        logic       wr, ld, md, mdr, br;
        logic       e_st, e_fi, e_fe;
        logic [1:0] e_f1, e_f2;
        logic       e_busy;
        int         e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic rst, input logic v,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic rsu, input logic rtu, input logic [4:0] rd,
                           input logic wr, input logic ld, input logic md,
                           input logic mdr, input logic br,
                           input logic st, input logic fi, input logic fe,
                           input logic [1:0] f1, input logic [1:0] f2,
                           input logic busy, input int cnt);
        vec_t t;
        t.rst = rst; t.v = v; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu;
        t.rd = rd; t.wr = wr; t.ld = ld; t.md = md; t.mdr = mdr; t.br = br;
        t.e_st = st; t.e_fi = fi; t.e_fe = fe; t.e_f1 = f1; t.e_f2 = f2;
        t.e_busy = busy; t.e_cnt = cnt;
        vq.push_back(t);
    endtask

    task automatic drive(input logic rst, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic rsu, input logic rtu, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic md,
                         input logic mdr, input logic br);
        rst_n = rst; iss_valid_i = v; iss_rs_i = rs; iss_rt_i = rt;
        iss_rs_used_i = rsu; iss_rt_used_i = rtu; iss_rd_i = rd;
        iss_reg_wr_i = wr; iss_mem_to_reg_i = ld; iss_md_i = md;
        iss_md_rd_i = mdr; ex_branch_taken_i = br;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // rst, v, rs, rt, rsu, rtu, rd, wr, ld, md, mdr, br | st, fi, fe, f1, f2, busy, cnt
        // lw r5 ; add r6,r5,r1 -> one load-use stall, then WB forward
        add_vec(1,1, 2,0, 1,0, 5, 1,1,0,0,0,  0,0,0, 2'b00,2'b00, 0,0);
        add_vec(1,1, 5,1, 1,1, 6, 1,0,0,0,0,  1,0,1, 2'b00,2'b00, 0,0);
        add_vec(1,1, 5,1, 1,1, 6, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b10,2'b00, 0,1);
        // add r3 ; add r4 ; sub r7,r3,r4 -> p1 WB, p2 MEM
        add_vec(1,1, 1,2, 1,1, 3, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 1,2, 1,1, 4, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 3,4, 1,1, 7, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b10,2'b01, 0,1);
        // two writers of r3 in MEM and WB -> MEM wins
        add_vec(1,1, 1,2, 1,1, 3, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 1,2, 1,1, 3, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 3,3, 1,1, 8, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b01,2'b01, 0,1);
        // addi r0 ; add r9,r0,r0 -> never forwards
        add_vec(1,1, 1,0, 1,0, 0, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 0,0, 1,1, 9, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        // lw r0 ; add r10,r0,r1 -> no load-use stall
        add_vec(1,1, 1,0, 1,0, 0, 1,1,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 0,1, 1,1,10, 1,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        // lw r5 ; add r6,r5,r1 with taken branch -> flush wins, no stall count
        add_vec(1,1, 2,0, 1,0, 5, 1,1,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 5,1, 1,1, 6, 1,0,0,0,1,  0,1,1, 2'b00,2'b00, 0,1);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        // reset, then mult ; mfhi -> 4 busy stall cycles
        add_vec(0,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,1, 1,2, 1,1, 0, 0,0,1,0,0,  0,0,0, 2'b00,2'b00, 0,0);
        add_vec(1,1, 0,0, 0,0,11, 1,0,0,1,0,  1,0,1, 2'b00,2'b00, 1,0);
        add_vec(1,1, 0,0, 0,0,11, 1,0,0,1,0,  1,0,1, 2'b00,2'b00, 1,1);
        add_vec(1,1, 0,0, 0,0,11, 1,0,0,1,0,  1,0,1, 2'b00,2'b00, 1,2);
        add_vec(1,1, 0,0, 0,0,11, 1,0,0,1,0,  1,0,1, 2'b00,2'b00, 1,3);
        add_vec(1,1, 0,0, 0,0,11, 1,0,0,1,0,  0,0,0, 2'b00,2'b00, 0,4);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,4);
        // mult, reset on its second busy cycle -> busy drops next cycle
        add_vec(1,1, 1,2, 1,1, 0, 0,0,1,0,0,  0,0,0, 2'b00,2'b00, 0,4);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 1,4);
        add_vec(0,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 1,4);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,0);
        // killed mult never loads the counter
        add_vec(1,1, 1,2, 1,1, 0, 0,0,1,0,1,  0,1,1, 2'b00,2'b00, 0,0);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b00,2'b00, 0,0);
        // lw r5 ; mult r5,r2 -> stalled mult does not load, then loads
        add_vec(1,1, 2,0, 1,0, 5, 1,1,0,0,0,  0,0,0, 2'b00,2'b00, 0,0);
        add_vec(1,1, 5,2, 1,1, 0, 0,0,1,0,0,  1,0,1, 2'b00,2'b00, 0,0);
        add_vec(1,1, 5,2, 1,1, 0, 0,0,1,0,0,  0,0,0, 2'b00,2'b00, 0,1);
        add_vec(1,0, 0,0, 0,0, 0, 0,0,0,0,0,  0,0,0, 2'b10,2'b00, 1,1);

        // reset state of both instances
        drive(0,0, 0,0, 0,0, 0, 0,0,0,0,0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); #2;
        chk("rst_a_stall", 0, {14'd0, a_sf, a_si}, 16'd0);
        chk("rst_a_flush", 0, {14'd0, a_fi, a_fe}, 16'd0);
        chk("rst_a_fwd",   0, {12'd0, a_f1, a_f2}, 16'd0);
        chk("rst_a_busy",  0, {15'd0, a_busy}, 16'd0);
        chk("rst_a_cnt",   0, a_cnt, 16'd0);
        chk("rst_b_all",   0, {9'd0, b_sf, b_si, b_fi, b_fe, b_f1, b_f2, b_busy}, 16'd0);
        chk("rst_b_cnt",   0, b_cnt, 16'd0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].v, vq[i].rs, vq[i].rt, vq[i].rsu, vq[i].rtu,
                  vq[i].rd, vq[i].wr, vq[i].ld, vq[i].md, vq[i].mdr, vq[i].br);
            #2;
            chk("stall_fetch", i, {15'd0, a_sf}, {15'd0, vq[i].e_st});
            chk("stall_iss",   i, {15'd0, a_si}, {15'd0, vq[i].e_st});
            chk("flush_iss",   i, {15'd0, a_fi}, {15'd0, vq[i].e_fi});
            chk("flush_ex",    i, {15'd0, a_fe}, {15'd0, vq[i].e_fe});
            chk("fwd_p1",      i, {14'd0, a_f1}, {14'd0, vq[i].e_f1});
            chk("fwd_p2",      i, {14'd0, a_f2}, {14'd0, vq[i].e_f2});
            chk("md_busy",     i, {15'd0, a_busy}, {15'd0, vq[i].e_busy});
            chk("stall_cnt",   i, a_cnt, vq[i].e_cnt[15:0]);
        end

        // stall-only instance: add r3 ; sub r7,r3,r4 -> exactly two stalls
        @(negedge clk); drive(0,0, 0,0, 0,0, 0, 0,0,0,0,0);
        @(negedge clk); drive(1,1, 1,2, 1,1, 3, 1,0,0,0,0); #2;
        chk("b_add_stall", 1, {14'd0, b_si, b_fe}, 16'd0);
        chk("b_rst_cnt",   1, b_cnt, 16'd0);
        @(negedge clk); drive(1,1, 3,4, 1,1, 7, 1,0,0,0,0); #2;
        chk("b_ex_stall",  2, {13'd0, b_sf, b_si, b_fe}, 16'h7);
        chk("b_ex_fwd",    2, {12'd0, b_f1, b_f2}, 16'd0);
        @(negedge clk); #2;
        chk("b_mem_stall", 3, {13'd0, b_sf, b_si, b_fe}, 16'h7);
        @(negedge clk); #2;
        chk("b_wb_nostall", 4, {13'd0, b_sf, b_si, b_fe}, 16'd0);
        @(negedge clk); drive(1,0, 0,0, 0,0, 0, 0,0,0,0,0); #2;
        chk("b_sub_fwd",   5, {12'd0, b_f1, b_f2}, 16'd0);
        chk("b_cnt",       5, b_cnt, 16'd2);
        @(negedge clk); #2;
        chk("b_fwd_after", 6, {12'd0, b_f1, b_f2}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter AW, default 5: register-address width; register 0 is hard-wired zero.
REQ-002 Parameter MD_LAT, default 32: mult/div occupancy in cycles, range 1..255.
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 iss_valid_i  in  1  valid instruction in ISS.
REQ-007 iss_rs_i, iss_rt_i  in  AW each  ISS source registers.
REQ-008 iss_rs_used_i, iss_rt_used_i  in  1 each  source actually read.
REQ-009 iss_rd_i  in  AW  ISS destination; iss_reg_wr_i  in  1  writes GPR.
REQ-010 iss_mem_to_reg_i  in  1  ISS instruction is a load.
REQ-011 iss_md_i  in  1  mult/div start; iss_md_rd_i  in  1  mfhi/mflo/mthi/mtlo.
REQ-012 ex_branch_taken_i  in  1  branch/jump in EX resolved taken.
REQ-013 stall_fetch_hz_o, stall_iss_hz_o  out  1 each  hold PC / hold ISS register.
REQ-014 flush_iss_hz_o  out  1  kill instruction in ISS; flush_ex_hz_o  out  1  bubble into EX next cycle.
REQ-015 fwd_p1_ex_mem_hz_o, fwd_p2_ex_mem_hz_o  out  2 each  EX operand select: 00 regfile, 01 MEM-stage result, 10 WB-stage result.
REQ-016 md_busy_hz_o  out  1  mult/div unit occupied.
REQ-017 stall_cnt_hz_o  out  16  saturating count of stall cycles.

Function
REQ-018 Block SHALL keep a 3-entry in-flight tracker (EX, MEM, WB), each entry: valid, rd, reg_wr, mem_to_reg; EX entry also holds rs, rt, rs_used, rt_used.
REQ-019 Tracker SHALL advance every cycle EX->MEM->WB->retired; EX loads the ISS instruction when iss_valid_i & ~stall_iss_hz_o & ~flush_iss_hz_o, otherwise an invalid bubble.
REQ-020 An entry with rd == 0 or reg_wr == 0 SHALL never cause a stall or forward.
REQ-021 Load-use (FWD_EN=1): valid load in EX whose rd matches a used ISS source -> stall_fetch, stall_iss, flush_ex = 1 for that cycle.
REQ-022 RAW (FWD_EN=0): valid writer in EX or MEM whose rd matches a used ISS source -> same three outputs = 1; WB match SHALL NOT stall (regfile is write-before-read).
REQ-023 MD hazard: iss_valid_i & (iss_md_i | iss_md_rd_i) & md_busy_hz_o -> same three outputs = 1.
REQ-024 Taken branch: flush_iss = flush_ex = 1, stall_fetch = stall_iss = 0; overrides all stall causes in the same cycle.
REQ-025 MD counter (8 bits) SHALL load MD_LAT on the edge an iss_md_i instruction enters EX, then decrement by 1 per cycle to 0; md_busy_hz_o = (counter != 0); a killed or stalled md instruction SHALL NOT load it.
REQ-026 Forward selects SHALL be combinational from the tracker for the EX-entry sources: MEM match -> 01, else WB match -> 10, else 00; MEM has priority when both match; loads in MEM SHALL NOT forward (load-use stall guarantees the WB case).
REQ-027 With FWD_EN=0 both forward selects SHALL be constant 00.
REQ-028 stall_cnt_hz_o SHALL increment on every cycle with stall_iss_hz_o=1 and hold at 16'hFFFF.

Reset
REQ-029 rst_n=0 at an edge SHALL clear all tracker valids, MD counter and stall counter; the cycle after, all outputs are 0 / 00, including mid-multiply.

Structure
REQ-030 Shared package holds forward-select encodings (FWD_RF, FWD_MEM, FWD_WB) and the tracker-entry struct.
REQ-031 One sub-module, hz_md_counter (load/decrement/busy), is natural; the rest stays flat.

Verification
REQ-032 lw r5 accepted into EX, add r6,r5,r1 in ISS -> 1 stall cycle (stall_fetch, stall_iss, flush_ex = 1); the add's EX cycle shows fwd_p1 = 10.
REQ-033 add r3 then add r4 then sub r7,r3,r4 back-to-back -> no stall; sub in EX shows fwd_p1 = 10, fwd_p2 = 01; two writers of r3 in MEM and WB -> 01.
REQ-034 addi r0 followed by a reader of r0 -> no stall, selects 00.
REQ-035 MD_LAT=4: mult enters EX, mfhi next in ISS -> md_busy for 4 cycles, 4 stall cycles, stall_cnt = 4; rst_n=0 at cycle 2 -> md_busy = 0 next cycle.
REQ-036 Taken branch in the same cycle as a load-use match -> flush_iss = flush_ex = 1, stalls 0, stall_cnt unchanged.
REQ-037 FWD_EN=0: add r3 then sub reading r3 -> exactly 2 stall cycles, selects always 00.
